// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - register-file address/data widths and types shared with the read mux
package rf_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    localparam rf_addr_t RF_ZERO_ADDR = 5'd0;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting at ptr
// Ports:
//   valid     : per-requester valid vector
//   ptr       : index that has highest priority this cycle (must be < NREQ)
//   g         : winning index (0 when nothing is valid)
//   any_valid : at least one requester is valid
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [$clog2(NREQ)-1:0] g,
    output logic                    any_valid
);

    localparam int PW = $clog2(NREQ);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Scan from the farthest offset down to offset 0 so that the last hit,
    // which wins, is the one closest to ptr.
    always_comb begin
        g         = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (valid[idx]) begin
                g         = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_read_arbiter.sv
// rtl/rf_read_arbiter.sv - round-robin arbiter for the shared register-file read port
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_addr  : per-requester read requests (5-bit address i at [5i+4:5i])
//   req_ready           : one-hot-or-zero grant
//   rf_se/rf_re/rf_data : register-file read port (data combinational from rf_se)
//   rsp_valid/rsp_ready : registered one-entry response stage with backpressure
//   rsp_data/rsp_id     : read data and the index of the requester it belongs to
module rf_read_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*RF_AW-1:0]   req_addr,
    output logic [NREQ-1:0]         req_ready,
    output rf_addr_t                rf_se,
    output logic                    rf_re,
    input  rf_data_t                rf_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output rf_data_t                rsp_data,
    output logic [$clog2(NREQ)-1:0] rsp_id
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] g;
    logic          any_valid;
    logic          can_load;
    logic          accept;
    rf_addr_t      addr_arr [NREQ];
    rf_addr_t      addr_g;
    rf_data_t      load_data;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[i*RF_AW +: RF_AW];
        end
    end

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (ptr),
        .g         (g),
        .any_valid (any_valid)
    );

    // The response slot can take new data when it is empty or being drained
    // this very edge, which gives back-to-back reads with no bubble.
    assign can_load = !rsp_valid || rsp_ready;
    assign accept   = any_valid && can_load;
    assign addr_g   = addr_arr[g];
    assign rf_se    = any_valid ? addr_g : RF_ZERO_ADDR;
    assign rf_re    = accept;

    always_comb begin
        req_ready    = '0;
        if (accept) begin
            req_ready[g] = 1'b1;
        end
    end

    assign load_data = (ZERO_R0 && (addr_g == RF_ZERO_ADDR)) ? '0 : rf_data;

    // Explicit wrap so non-power-of-2 NREQ never lets ptr reach NREQ.
    assign ptr_nxt = (g == PW'(NREQ - 1)) ? '0 : g + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (accept) begin
            ptr       <= ptr_nxt;
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
            rsp_id    <= g;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// tb/tb_rf_read_arbiter.sv - self-checking bench for rf_read_arbiter (NREQ=4/ZERO_R0=1 and NREQ=3/ZERO_R0=0)
module tb_rf_read_arbiter;

    logic        clk;
    logic        rst_n;

    logic [3:0]  req_valid;
    logic [19:0] req_addr;
    logic [3:0]  req_ready;
    logic [4:0]  rf_se;
    logic        rf_re;
    logic [31:0] rf_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_id;

    logic [2:0]  req_valid3;
    logic [14:0] req_addr3;
    logic [2:0]  req_ready3;
    logic [4:0]  rf_se3;
    logic        rf_re3;
    logic [31:0] rf_data3;
    logic        rsp_valid3;
    logic        rsp_ready3;
    logic [31:0] rsp_data3;
    logic [1:0]  rsp_id3;

    logic [31:0] regs [32];

    int n_checks;
    int n_fail;

    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_id;

    assign rf_data  = regs[rf_se];
    assign rf_data3 = regs[rf_se3];

    rf_read_arbiter #(.NREQ(4), .ZERO_R0(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rf_se(rf_se), .rf_re(rf_re), .rf_data(rf_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    rf_read_arbiter #(.NREQ(3), .ZERO_R0(1'b0)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_addr(req_addr3), .req_ready(req_ready3),
        .rf_se(rf_se3), .rf_re(rf_re3), .rf_data(rf_data3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_id(rsp_id3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int winner(input logic [3:0] v, input int p, input int n);
        int i;
        for (int k = 0; k < n; k++) begin
            i = (p + k) % n;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic idle_inputs;
        req_valid  = '0;
        req_addr   = '0;
        rsp_ready  = 1'b1;
        req_valid3 = '0;
        req_addr3  = '0;
        rsp_ready3 = 1'b1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        req_addr  = {15'd0, 5'd9};
        rsp_ready = 1'b0;
        req_valid3 = 3'b001;
        req_addr3  = {10'd0, 5'd9};
        rsp_ready3 = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_setup_valid: got %0b want 1", rsp_valid);
        end
        @(negedge clk);
        req_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid);
        end
        n_checks++;
        if (rsp_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_rsp_data: got %h want 00000000", rsp_data);
        end
        n_checks++;
        if (rsp_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id);
        end
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL reset_ptr_grant: got %b want 0001", req_ready);
        end
        n_checks++;
        if (rsp_valid3 !== 1'b0 || rsp_data3 !== 32'h0) begin
            n_fail++; $display("FAIL reset_dut3: got valid %0b data %h want 0/0", rsp_valid3, rsp_data3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_single_read;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        req_addr  = {15'd0, 5'd9};
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001 || rf_se !== 5'd9 || rf_re !== 1'b1) begin
            n_fail++; $display("FAIL single_comb: got ready %b se %0d re %0b want 0001 9 1", req_ready, rf_se, rf_re);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || rsp_id !== 2'd0) begin
            n_fail++; $display("FAIL single_rsp: got v %0b d %h id %0d want 1 deadbeef 0", rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_round_robin;
        do_reset();
        @(negedge clk);
        req_valid = 4'b1111;
        req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_data !== regs[(k % 4) + 1]) begin
                n_fail++; $display("FAIL rr_seq[%0d]: got v %0b id %0d d %h want 1 %0d %h",
                                   k, rsp_valid, rsp_id, rsp_data, k % 4, regs[(k % 4) + 1]);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_backpressure;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        req_addr  = {15'd0, 5'd9};
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_addr  = {10'd0, 5'd5, 5'd0};
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000 || rf_re !== 1'b0) begin
                n_fail++; $display("FAIL bp_stall[%0d]: got ready %b re %0b want 0000 0", k, req_ready, rf_re);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || rsp_id !== 2'd0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v %0b d %h id %0d want 1 deadbeef 0", k, rsp_valid, rsp_data, rsp_id);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010 || rf_re !== 1'b1 || rf_se !== 5'd5) begin
            n_fail++; $display("FAIL bp_release: got ready %b re %0b se %0d want 0010 1 5", req_ready, rf_re, rf_se);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE_0005 || rsp_id !== 2'd1) begin
            n_fail++; $display("FAIL bp_replace: got v %0b d %h id %0d want 1 cafe0005 1", rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got %0b want 0", rsp_valid);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_zero_reg;
        do_reset();
        @(negedge clk);
        req_valid  = 4'b0001;
        req_addr   = {15'd0, 5'd9};
        req_valid3 = 3'b001;
        req_addr3  = {10'd0, 5'd0};
        @(negedge clk);
        req_addr   = {15'd0, 5'd0};
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
            n_fail++; $display("FAIL zero_r0_on: got v %0b d %h want 1 00000000", rsp_valid, rsp_data);
        end
        n_checks++;
        if (rsp_valid3 !== 1'b1 || rsp_data3 !== 32'h1234_5678 || rsp_id3 !== 2'd0) begin
            n_fail++; $display("FAIL zero_r0_off: got v %0b d %h id %0d want 1 12345678 0", rsp_valid3, rsp_data3, rsp_id3);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_non_pow2;
        do_reset();
        @(negedge clk);
        req_valid3 = 3'b111;
        req_addr3  = {5'd3, 5'd2, 5'd1};
        rsp_ready3 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (rsp_valid3 !== 1'b1 || rsp_id3 !== 2'(k % 3) || rsp_data3 !== regs[(k % 3) + 1]) begin
                n_fail++; $display("FAIL np2_seq[%0d]: got v %0b id %0d d %h want 1 %0d %h",
                                   k, rsp_valid3, rsp_id3, rsp_data3, k % 3, regs[(k % 3) + 1]);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random;
        logic [3:0]  v;
        logic [19:0] a;
        logic [3:0]  prev_grant;
        logic [3:0]  exp_ready;
        logic [4:0]  exp_se;
        logic [4:0]  ag;
        int          w;
        bit          acc;
        bit          rdy;
        int          waits [4];
        do_reset();
        v = '0;
        a = '0;
        prev_grant = '0;
        for (int i = 0; i < 4; i++) waits[i] = 0;
        repeat (400) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!(v[i] && !prev_grant[i])) begin
                    v[i] = ($urandom_range(0, 99) < 60);
                    a[i*5 +: 5] = 5'($urandom_range(0, 31));
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            req_valid = v;
            req_addr  = a;
            rsp_ready = rdy;
            #1;
            w   = winner(v, m_ptr, 4);
            acc = (w >= 0) && (!m_valid || rdy);
            exp_ready = '0;
            if (acc) exp_ready[w] = 1'b1;
            exp_se = (w >= 0) ? a[w*5 +: 5] : 5'd0;
            n_checks++;
            if (req_ready !== exp_ready || rf_re !== acc || rf_se !== exp_se) begin
                n_fail++; $display("FAIL rand_comb: got ready %b re %0b se %0d want %b %0b %0d",
                                   req_ready, rf_re, rf_se, exp_ready, acc, exp_se);
            end
            for (int i = 0; i < 4; i++) if (!v[i]) waits[i] = 0;
            if (acc) begin
                n_checks++;
                if (waits[w] > 3) begin
                    n_fail++; $display("FAIL rand_fairness: requester %0d waited %0d accepts, limit 3", w, waits[w]);
                end
                for (int i = 0; i < 4; i++) if (v[i] && i != w) waits[i]++;
                waits[w] = 0;
            end
            prev_grant = exp_ready;
            @(posedge clk);
            if (acc) begin
                ag      = a[w*5 +: 5];
                m_data  = (ag == 5'd0) ? 32'h0 : regs[ag];
                m_id    = w;
                m_valid = 1'b1;
                m_ptr   = (w + 1) % 4;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (rsp_valid !== m_valid || rsp_data !== m_data || rsp_id !== 2'(m_id)) begin
                n_fail++; $display("FAIL rand_rsp: got v %0b d %h id %0d want %0b %h %0d",
                                   rsp_valid, rsp_data, rsp_id, m_valid, m_data, m_id);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'h1234_5678;
        regs[5] = 32'hCAFE_0005;
        regs[9] = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_backpressure();
        test_zero_reg();
        test_non_pow2();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_read_arbiter.md
# rf_read_arbiter

Round-robin arbiter sharing the single 32:1 register-file read port (5-bit select, 32-bit data) among NREQ requesters. Each requester issues a register address with a valid/ready handshake. The arbiter drives the port select and read enable, captures the combinational read data, and returns it through a one-entry registered response stage with backpressure. It sits between the decode/hazard logic and the register-file read mux.

## Interface

**Parameters**
- NREQ, default 4: number of requesters; legal range 2..8.
- ZERO_R0, default 1: when 1, address 0 returns 32'h0 regardless of port data (MIPS $zero).

**Ports**
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, NREQ: per-requester request valid.
- req_addr, input, NREQ*5: register address for requester i, at bits [5i+4:5i]; held stable while valid and not ready.
- req_ready, output, NREQ: one-hot-or-zero grant; request i is accepted in a cycle where req_valid[i] and req_ready[i] are both high.
- rf_se, output, 5: read-port select.
- rf_re, output, 1: read-port enable.
- rf_data, input, 32: read-port data, combinational from rf_se.
- rsp_valid, output, 1: response valid.
- rsp_ready, input, 1: consumer accepts the response.
- rsp_data, output, 32: read data.
- rsp_id, output, clog2(NREQ): index of the requester the data belongs to.

## Operation

**Priority pointer**
- ptr, clog2(NREQ) bits, resets to 0.
- Winner g is the first i with req_valid[i] high, scanning ptr, ptr+1, … modulo NREQ.

**Accept condition**
- can_load = !rsp_valid || rsp_ready.
- accept = (|req_valid) && can_load.

**Combinational outputs**
- req_ready[g] = accept; all other req_ready bits are 0.
- rf_se = req_addr[g] when |req_valid, else 5'd0.
- rf_re = accept.

**On accept**
- rsp_data <= (ZERO_R0 && addr_g == 0) ? 32'h0 : rf_data.
- rsp_id <= g.
- rsp_valid <= 1.
- ptr <= (g+1) mod NREQ. The wrap is explicit for non-power-of-2 NREQ.

**No accept**
- If rsp_ready is high, rsp_valid <= 0.
- Otherwise rsp_valid, rsp_data and rsp_id hold.
- ptr holds whenever there is no accept.

**Boundary conditions**
- Simultaneous drain and load (rsp_valid && rsp_ready && a request present): the new response replaces the old one in the same edge, with no bubble.
- Output full (rsp_valid && !rsp_ready): all req_ready are 0, and rf_re is 0.
- A single persistent requester is granted every cycle. ptr tracks it.
- Reset asserted mid-operation: response state is discarded immediately and nothing is replayed.

**Reset values**
- rsp_valid 0, rsp_data 32'h0, rsp_id 0, ptr 0.
- req_ready, rf_se and rf_re follow from these reset values combinationally.

## Timing

- Latency: accept in cycle N gives rsp_valid high from the edge ending cycle N, visible in cycle N+1.
- Throughput: one read per cycle while rsp_ready stays high.
- rf_data is sampled on the same edge as the accept, so the path req_addr -> rf_se -> mux -> rsp_data must close in one cycle.
- No combinational path from rf_data to any output.
- rsp_ready -> req_ready/rf_re is combinational by design.
- Fairness: a continuously asserted request waits at most NREQ-1 accepts before it is granted.

## Structure

- Shared package rf_pkg:
  - RF_AW = 5
  - RF_DW = 32
  - RF_ZERO_ADDR = 5'd0
  - rf_addr_t / rf_data_t typedefs, shared with the register file and its read mux.
- One sub-module, rr_pick:
  - Combinational.
  - Inputs: valid vector and ptr.
  - Outputs: winner index g and any_valid.
  - Instantiated once.
- The top level holds ptr, the response register, and the handshake logic.

## Test plan

1. **Reset:** assert rst_n=0 mid-response -> rsp_valid=0, rsp_data=0, ptr=0 immediately, with no clock edge required.
2. **Single read:** req_valid=4'b0001, addr=5'd9, rf_data=32'hDEAD_BEEF, rsp_ready=1 -> req_ready=4'b0001, rf_se=9, rf_re=1; next cycle rsp_valid=1, rsp_data=DEADBEEF, rsp_id=0.
3. **Round-robin:** all four valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 over five consecutive cycles.
4. **Backpressure:** rsp_ready=0 with rsp_valid=1 -> req_ready=0, rf_re=0, rsp_data stable for 3 cycles. Raising rsp_ready with a request pending -> new data loads on that edge and rsp_valid stays 1.
5. **Register zero:** ZERO_R0=1, addr=0, rf_data=32'h1234_5678 -> rsp_data=32'h0. With ZERO_R0=0 -> rsp_data=32'h1234_5678.
6. **Non-power-of-2:** NREQ=3, all valid -> rsp_id sequence 0,1,2,0; ptr never reaches 3.
